// File: rtl/stl_onehot_chk_mon.sv
// stl_onehot_chk_mon -- registered multi-channel one-hot checker and monitor.
//
// Each cycle, CH independent WIDTH-bit vectors are classified as exactly
// one-hot, zero, or multi-hot. A per-channel verdict and the encoded bit
// index are registered. Violations latch into sticky, counter and
// first-error debug state.
//
// Ports:
//   clk_i            rising-edge clock
//   rst_n_i          asynchronous active-low reset
//   vld_i[CH]        per-channel sample strobe
//   data_i           channel c at [c*WIDTH +: WIDTH]
//   clr_i            synchronous clear of sticky/counter/first-error state
//   res_vld_o[CH]    one-cycle verdict strobe, 1+PIPE cycles after sampling
//   onehot_o[CH]     sample legal under MODE
//   zero_o[CH]       sample was all-zero
//   idx_o            per-channel binary index of the set bit (0 unless exact)
//   err_sticky_o[CH] latched per-channel violation
//   err_cnt_o        saturating count of violation events
//   first_err_ch_o   channel of the first recorded violation
//   first_err_data_o vector of the first recorded violation
//   first_err_vld_o  first-error capture holds data
module stl_onehot_chk_mon #(
  parameter int WIDTH = 16,
  parameter int CH    = 2,
  parameter int MODE  = 0,
  parameter int PIPE  = 0,
  parameter int CNT_W = 8
) (
  input  logic                                clk_i,
  input  logic                                rst_n_i,
  input  logic [CH-1:0]                       vld_i,
  input  logic [CH*WIDTH-1:0]                 data_i,
  input  logic                                clr_i,
  output logic [CH-1:0]                       res_vld_o,
  output logic [CH-1:0]                       onehot_o,
  output logic [CH-1:0]                       zero_o,
  output logic [CH*$clog2(WIDTH)-1:0]         idx_o,
  output logic [CH-1:0]                       err_sticky_o,
  output logic [CNT_W-1:0]                    err_cnt_o,
  output logic [((CH > 1) ? $clog2(CH) : 1)-1:0] first_err_ch_o,
  output logic [WIDTH-1:0]                    first_err_data_o,
  output logic                                first_err_vld_o
);

  localparam int IW = $clog2(WIDTH);
  localparam int PW = 1 << IW;
  localparam int CW = (CH > 1) ? $clog2(CH) : 1;
  localparam int SW = CNT_W + $clog2(CH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Balanced pairwise tree over the zero-padded vector. Each node carries
  // xor, any-set and two-or-more; pad bits are zero so they never set any.
  function automatic logic tree_exact(input logic [WIDTH-1:0] d);
    logic [PW-1:0] x, a, m;
    x = PW'(d);
    a = x;
    m = '0;
    for (int lvl = 1; lvl < PW; lvl = lvl * 2) begin
      for (int i = 0; i < PW; i = i + 2 * lvl) begin
        m[i] = m[i] | m[i+lvl] | (a[i] & a[i+lvl]);
        x[i] = x[i] ^ x[i+lvl];
        a[i] = a[i] | a[i+lvl];
      end
    end
    return x[0] & ~m[0];
  endfunction

  // Bitwise encode: OR of the positions of all set bits.
  function automatic logic [IW-1:0] encode(input logic [WIDTH-1:0] d);
    logic [IW-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (d[i]) r = r | IW'(i);
    end
    return r;
  endfunction

  // ---- stage p0: reduction tree on the raw inputs ----
  logic [CH-1:0]       vld_p0, exact_p0, zero_p0;
  logic [CH*IW-1:0]    idx_p0;
  logic [CH*WIDTH-1:0] data_p0;

  always_comb begin
    vld_p0   = vld_i;
    data_p0  = data_i;
    exact_p0 = '0;
    zero_p0  = '0;
    idx_p0   = '0;
    for (int c = 0; c < CH; c++) begin
      exact_p0[c] = tree_exact(data_i[c*WIDTH +: WIDTH]);
      zero_p0[c]  = ~|data_i[c*WIDTH +: WIDTH];
      idx_p0[c*IW +: IW] = exact_p0[c] ? encode(data_i[c*WIDTH +: WIDTH]) : '0;
    end
  end

  // ---- stage p1: optional register after the tree ----
  logic [CH-1:0]       vld_p1, exact_p1, zero_p1;
  logic [CH*IW-1:0]    idx_p1;
  logic [CH*WIDTH-1:0] data_p1;

  if (PIPE != 0) begin : g_pipe
    logic [CH-1:0]       vld_p1_q, exact_p1_q, zero_p1_q;
    logic [CH*IW-1:0]    idx_p1_q;
    logic [CH*WIDTH-1:0] data_p1_q;

    // Only the strobe is reset, so a reset drops in-flight samples.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) vld_p1_q <= '0;
      else          vld_p1_q <= vld_p0;
    end

    always_ff @(posedge clk_i) begin
      exact_p1_q <= exact_p0;
      zero_p1_q  <= zero_p0;
      idx_p1_q   <= idx_p0;
      data_p1_q  <= data_p0;
    end

    assign vld_p1   = vld_p1_q;
    assign exact_p1 = exact_p1_q;
    assign zero_p1  = zero_p1_q;
    assign idx_p1   = idx_p1_q;
    assign data_p1  = data_p1_q;
  end else begin : g_nopipe
    assign vld_p1   = vld_p0;
    assign exact_p1 = exact_p0;
    assign zero_p1  = zero_p0;
    assign idx_p1   = idx_p0;
    assign data_p1  = data_p0;
  end

  logic [CH-1:0] ok_p1, viol_p1;
  assign ok_p1   = (MODE != 0) ? (exact_p1 | zero_p1) : exact_p1;
  // Gating by the strobe keeps unqualified (even X) data from raising errors.
  assign viol_p1 = vld_p1 & ~ok_p1;

  // ---- output stage: verdicts and error bookkeeping ----
  logic [CH-1:0]       res_vld_q, onehot_q, zero_q, sticky_q, sticky_d;
  logic [CH*IW-1:0]    idx_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]       fch_q, fch_d;
  logic [WIDTH-1:0]    fdata_q, fdata_d;
  logic                fvld_q, fvld_d;
  logic [SW-1:0]       pop, sum;

  // Clear is applied before the same-edge violation is folded in.
  always_comb begin
    sticky_d = (clr_i ? '0 : sticky_q) | viol_p1;
    pop = '0;
    for (int c = 0; c < CH; c++) pop = pop + SW'(viol_p1[c]);
    sum   = SW'(clr_i ? '0 : cnt_q) + pop;
    cnt_d = (sum > SW'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
    fvld_d  = clr_i ? 1'b0 : fvld_q;
    fch_d   = clr_i ? '0 : fch_q;
    fdata_d = clr_i ? '0 : fdata_q;
    if (!fvld_d && (|viol_p1)) begin
      fvld_d = 1'b1;
      // Descending scan so the lowest violating channel is the one kept.
      for (int c = CH - 1; c >= 0; c--) begin
        if (viol_p1[c]) begin
          fch_d   = CW'(c);
          fdata_d = data_p1[c*WIDTH +: WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      res_vld_q <= '0;
      onehot_q  <= '0;
      zero_q    <= '0;
      idx_q     <= '0;
      sticky_q  <= '0;
      cnt_q     <= '0;
      fch_q     <= '0;
      fdata_q   <= '0;
      fvld_q    <= 1'b0;
    end else begin
      res_vld_q <= vld_p1;
      for (int c = 0; c < CH; c++) begin
        if (vld_p1[c]) begin
          onehot_q[c]        <= ok_p1[c];
          zero_q[c]          <= zero_p1[c];
          idx_q[c*IW +: IW]  <= idx_p1[c*IW +: IW];
        end
      end
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
      fch_q    <= fch_d;
      fdata_q  <= fdata_d;
      fvld_q   <= fvld_d;
    end
  end

  assign res_vld_o        = res_vld_q;
  assign onehot_o         = onehot_q;
  assign zero_o           = zero_q;
  assign idx_o            = idx_q;
  assign err_sticky_o     = sticky_q;
  assign err_cnt_o        = cnt_q;
  assign first_err_ch_o   = fch_q;
  assign first_err_data_o = fdata_q;
  assign first_err_vld_o  = fvld_q;

endmodule

// File: tb/tb_stl_onehot_chk_mon.sv
// Directed bench for stl_onehot_chk_mon over four configurations:
//   A: WIDTH=16 CH=2 MODE=0 PIPE=0 CNT_W=8
//   B: as A with MODE=1
//   C: as A with PIPE=1 CNT_W=2
//   D: WIDTH=5 CH=1 MODE=0 PIPE=0 CNT_W=8
// A, B and C share stimulus; D has its own strobe and data.
module tb_stl_onehot_chk_mon;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  vld;
  logic [31:0] data;
  logic        clr;
  logic        vld_d;
  logic [4:0]  data_d;

  logic [1:0]  a_rv, a_oh, a_z, a_st;  logic [7:0] a_idx; logic [7:0] a_cnt;
  logic [0:0]  a_fch; logic [15:0] a_fd; logic a_fv;
  logic [1:0]  b_rv, b_oh, b_z, b_st;  logic [7:0] b_idx; logic [7:0] b_cnt;
  logic [0:0]  b_fch; logic [15:0] b_fd; logic b_fv;
  logic [1:0]  c_rv, c_oh, c_z, c_st;  logic [7:0] c_idx; logic [1:0] c_cnt;
  logic [0:0]  c_fch; logic [15:0] c_fd; logic c_fv;
  logic [0:0]  d_rv, d_oh, d_z, d_st;  logic [2:0] d_idx; logic [7:0] d_cnt;
  logic [0:0]  d_fch; logic [4:0] d_fd; logic d_fv;

  int ncmp = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  stl_onehot_chk_mon #(.WIDTH(16), .CH(2), .MODE(0), .PIPE(0), .CNT_W(8)) u_a (
    .clk_i(clk), .rst_n_i(rst_n), .vld_i(vld), .data_i(data), .clr_i(clr),
    .res_vld_o(a_rv), .onehot_o(a_oh), .zero_o(a_z), .idx_o(a_idx),
    .err_sticky_o(a_st), .err_cnt_o(a_cnt), .first_err_ch_o(a_fch),
    .first_err_data_o(a_fd), .first_err_vld_o(a_fv));

  stl_onehot_chk_mon #(.WIDTH(16), .CH(2), .MODE(1), .PIPE(0), .CNT_W(8)) u_b (
    .clk_i(clk), .rst_n_i(rst_n), .vld_i(vld), .data_i(data), .clr_i(clr),
    .res_vld_o(b_rv), .onehot_o(b_oh), .zero_o(b_z), .idx_o(b_idx),
    .err_sticky_o(b_st), .err_cnt_o(b_cnt), .first_err_ch_o(b_fch),
    .first_err_data_o(b_fd), .first_err_vld_o(b_fv));

  stl_onehot_chk_mon #(.WIDTH(16), .CH(2), .MODE(0), .PIPE(1), .CNT_W(2)) u_c (
    .clk_i(clk), .rst_n_i(rst_n), .vld_i(vld), .data_i(data), .clr_i(clr),
    .res_vld_o(c_rv), .onehot_o(c_oh), .zero_o(c_z), .idx_o(c_idx),
    .err_sticky_o(c_st), .err_cnt_o(c_cnt), .first_err_ch_o(c_fch),
    .first_err_data_o(c_fd), .first_err_vld_o(c_fv));

  stl_onehot_chk_mon #(.WIDTH(5), .CH(1), .MODE(0), .PIPE(0), .CNT_W(8)) u_d (
    .clk_i(clk), .rst_n_i(rst_n), .vld_i(vld_d), .data_i(data_d), .clr_i(clr),
    .res_vld_o(d_rv), .onehot_o(d_oh), .zero_o(d_z), .idx_o(d_idx),
    .err_sticky_o(d_st), .err_cnt_o(d_cnt), .first_err_ch_o(d_fch),
    .first_err_data_o(d_fd), .first_err_vld_o(d_fv));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; vld = '0; data = '0; clr = 1'b0; vld_d = 1'b0; data_d = '0;
    tick(); tick();
    chk("rst a_rv", a_rv, 0);   chk("rst a_oh", a_oh, 0);
    chk("rst a_idx", a_idx, 0); chk("rst a_cnt", a_cnt, 0);
    chk("rst a_fv", a_fv, 0);   chk("rst c_rv", c_rv, 0);
    chk("rst d_oh", d_oh, 0);
    rst_n = 1'b1;

    // single legal sample on ch0
    vld = 2'b01; data = 32'h0000_0040;
    tick();
    chk("s1 a_rv", a_rv, 2'b01);  chk("s1 a_oh", a_oh, 2'b01);
    chk("s1 a_idx0", a_idx[3:0], 6); chk("s1 a_cnt", a_cnt, 0);
    chk("s1 a_st", a_st, 0);      chk("s1 c_rv early", c_rv, 0);
    vld = 2'b00; data = 32'hFFFF_FFFF;
    tick();
    chk("s1 a_rv pulse", a_rv, 0); chk("s1 a_oh held", a_oh, 2'b01);
    chk("s1 a_idx held", a_idx[3:0], 6);
    chk("s1 c_rv", c_rv, 2'b01);  chk("s1 c_oh", c_oh, 2'b01);
    chk("s1 c_idx0", c_idx[3:0], 6); chk("s1 a_cnt idle", a_cnt, 0);

    // ch1 zero then multi-hot
    vld = 2'b10; data = 32'h0000_0000;
    tick();
    chk("s2 a_oh1", a_oh[1], 0);  chk("s2 a_z1", a_z[1], 1);
    chk("s2 a_cnt", a_cnt, 1);    chk("s2 a_fch", a_fch, 1);
    chk("s2 b_oh1 zero legal", b_oh[1], 1); chk("s2 b_z1", b_z[1], 1);
    chk("s2 b_idx1", b_idx[7:4], 0); chk("s2 b_cnt", b_cnt, 0);
    vld = 2'b10; data = 32'h0300_0000;
    tick();
    chk("s3 a_oh1", a_oh[1], 0);  chk("s3 a_z1", a_z[1], 0);
    chk("s3 a_idx1", a_idx[7:4], 0); chk("s3 a_st", a_st, 2'b10);
    chk("s3 a_cnt", a_cnt, 2);    chk("s3 a_fch", a_fch, 1);
    chk("s3 a_fd", a_fd, 16'h0000); chk("s3 a_fv", a_fv, 1);
    chk("s3 b_cnt", b_cnt, 1);    chk("s3 b_fd", b_fd, 16'h0300);
    chk("s3 c_cnt", c_cnt, 1);
    vld = 2'b00;
    tick();
    chk("s3 c_cnt2", c_cnt, 2);   chk("s3 c_fch", c_fch, 1);

    // clear, then dual violation, then clear coinciding with a new violation
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr a_cnt", a_cnt, 0);   chk("clr a_st", a_st, 0);
    chk("clr a_fv", a_fv, 0);     chk("clr c_cnt", c_cnt, 0);
    vld = 2'b11; data = 32'h0003_0003;
    tick();
    chk("s4 a_cnt", a_cnt, 2);    chk("s4 a_fch", a_fch, 0);
    chk("s4 a_fd", a_fd, 16'h0003); chk("s4 a_st", a_st, 2'b11);
    chk("s4 a_oh", a_oh, 2'b00);  chk("s4 b_cnt", b_cnt, 2);
    vld = 2'b10; data = 32'h0300_0000; clr = 1'b1;
    tick();
    vld = 2'b00; clr = 1'b0;
    chk("s5 a_cnt", a_cnt, 1);    chk("s5 a_fch", a_fch, 1);
    chk("s5 a_fd", a_fd, 16'h0300); chk("s5 a_st", a_st, 2'b10);
    chk("s5 c_cnt", c_cnt, 2);    chk("s5 c_fch", c_fch, 0);
    tick();
    chk("s5 c_cnt sat", c_cnt, 3); chk("s5 c_st", c_st, 2'b11);
    chk("s5 a_cnt hold", a_cnt, 1);

    // saturation on the 2-bit counter of the pipelined instance
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("s6 c_cnt clr", c_cnt, 0);
    vld = 2'b01; data = 32'h0000_0000;
    tick();
    chk("s6 c_rv lat", c_rv, 0);  chk("s6 c_cnt0", c_cnt, 0);
    tick();
    chk("s6 c_rv", c_rv, 2'b01);  chk("s6 c_cnt1", c_cnt, 1);
    tick();  chk("s6 c_cnt2", c_cnt, 2);
    tick();  chk("s6 c_cnt3", c_cnt, 3);
    tick();  chk("s6 c_cnt4", c_cnt, 3);
    vld = 2'b00;
    tick();  chk("s6 c_cnt5", c_cnt, 3);
    chk("s6 a_cnt", a_cnt, 5);    chk("s6 a_fd", a_fd, 16'h0000);

    // non-power-of-two width
    vld_d = 1'b1; data_d = 5'h10;
    tick();
    chk("d oh 0x10", d_oh, 1);    chk("d idx 0x10", d_idx, 4);
    chk("d rv", d_rv, 1);
    data_d = 5'h11;
    tick();
    chk("d oh 0x11", d_oh, 0);    chk("d idx 0x11", d_idx, 0);
    chk("d cnt", d_cnt, 1);       chk("d fd", d_fd, 5'h11);
    data_d = 5'h04;
    tick();
    vld_d = 1'b0;
    chk("d oh 0x04", d_oh, 1);    chk("d idx 0x04", d_idx, 2);

    // reset in the middle of a pipelined sample
    vld = 2'b01; data = 32'h0000_0040;
    tick();
    vld = 2'b00;
    chk("r a_oh pre", a_oh, 2'b01);
    #2 rst_n = 1'b0;
    #1;
    chk("r a_rv", a_rv, 0);       chk("r a_oh", a_oh, 0);
    chk("r a_idx", a_idx, 0);     chk("r a_cnt", a_cnt, 0);
    chk("r a_fv", a_fv, 0);       chk("r c_cnt", c_cnt, 0);
    chk("r d_oh", d_oh, 0);       chk("r d_fv", d_fv, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("r c_rv post1", c_rv, 0); chk("r a_rv post1", a_rv, 0);
    tick();
    chk("r c_rv post2", c_rv, 0); chk("r c_oh post2", c_oh, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
